quad_decoder: RTL
=================

# quad_decoder

Parametrised multi-channel quadrature decoder that replaces the single-channel, single-edge, 2-bit rotary encoder. It does full 4x Gray-code decoding with input synchronisation, configurable counter width and a selectable wrap or saturate mode, and provides per-channel step and direction strobes. It sits between the raw encoder pins (paddle knobs) and the game logic that consumes paddle positions.

## Interface
Parameters:
- `CHANNELS`, default 2: number of independent encoders.
- `WIDTH`, default 8: per-channel count width in bits.
- `SYNC_STAGES`, default 2: synchroniser flops per input pin, minimum 2.
- `SATURATE`, default 0: 0 wraps the count modulo 2^WIDTH; 1 clamps it at 0 and 2^WIDTH-1.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high reset.
- `a` input CHANNELS: encoder phase A, asynchronous, bit i belongs to channel i.
- `b` input CHANNELS: encoder phase B, asynchronous.
- `zero` input CHANNELS: synchronous clear of channel i's count.
- `value` output CHANNELS*WIDTH: counts; channel i occupies bits [i*WIDTH +: WIDTH].
- `step` output CHANNELS: one-cycle pulse whenever channel i's count changes.
- `dir` output CHANNELS: direction of the last counted step; 1 means up.
- `err` output CHANNELS: sticky illegal-transition flag (see Configuration).

## Operation
- Each pin passes through SYNC_STAGES flops. `cur` is the synchronised {a,b}; `prev` is `cur` delayed by one cycle.
- Up sequence ({a,b}): 00→10→11→01→00. Each of these transitions adds +1.
- Down sequence is the reverse: 00→01→11→10→00. Each adds -1.
- `cur == prev` means no change.
- A transition in which both bits change (00↔11, 10↔01) is illegal. The count is unchanged and no step is issued.
- Arithmetic is WIDTH-bit.
  - SATURATE=0: 2^WIDTH-1 plus 1 gives 0, and 0 minus 1 gives 2^WIDTH-1; `step` pulses in both cases.
  - SATURATE=1: an increment at max or a decrement at 0 leaves the count unchanged, and `step` does not pulse.
- `zero` has priority over a simultaneous step. The count becomes 0, `step` stays 0 and `dir` is held.
- Priming: after reset deassertion, one shared counter runs for SYNC_STAGES+1 cycles.
  - During this window `prev` tracks `cur` and nothing is counted.
  - Encoder levels that are static at power-up therefore never produce steps.
- Reset values: `value`=0, `step`=0, `dir`=0, `err`=0, all sync/prev flops=0, prime counter restarted.
- Reset asserted mid-operation aborts everything in the cycle it is sampled, and priming is repeated.
- Channels are fully independent. Simultaneous steps on different channels are all counted in the same cycle.

## Timing
- Latency from pin edge (meeting setup) to `value`/`step`/`dir` update: SYNC_STAGES+1 clk edges, i.e. 3 cycles at default.
- `step` is high for exactly one cycle per counted transition and is coincident with the new `value`.
- `value`, `step`, `dir` and `err` are all registered. There are no combinational paths from inputs to outputs.
- `zero` takes effect on the next edge, so `value` reads 0 one cycle after `zero` is sampled.
- Maximum trackable rate: one Gray transition per clk cycle per channel. Faster input is undefined, but detected as illegal when QUAD_ERR_EN is defined.

## Configuration
- Macro: `QUAD_ERR_EN`.
- Defined:
  - Every illegal transition sets `err[i]`.
  - `err[i]` stays set until `reset` or until `zero[i]`.
  - `zero[i]` clears `err[i]`, and `err` is set if an illegal transition occurs in the same cycle as the clear.
- Undefined:
  - `err` is tied to 0.
  - Illegal transitions are still ignored for counting.
  - No error logic is synthesised.

## Structure
- Package `quad_pkg` contains:
  - the 2-bit phase state constants (S00, S10, S11, S01);
  - a step-kind enum (NONE, UP, DOWN, ILLEGAL);
  - a pure function `quad_decode(prev, cur)` returning that enum.
- Sub-module `quad_channel` holds one channel: synchroniser, prev register, counter, step/dir/err. It is instantiated CHANNELS times in a generate loop.
- The top level holds only the shared prime counter and the port packing.

## Test plan
- Reset with a=b=1 on ch0, then hold 20 cycles → `value` stays 0 and `step` never pulses.
- After priming, drive ch0 {a,b} through 00,10,11,01,00, one change every 4 cycles → `value[ch0]`=4, 4 step pulses, `dir`=1, each update 3 cycles after its pin change.
- WIDTH=8, SATURATE=0, count at 255, one up step → 0 with a step pulse. With SATURATE=1 the same stimulus → stays 255 with no step pulse; at 0 with a down step → stays 0.
- Ch1 drives 00→11 → `value[ch1]` unchanged, no step. With QUAD_ERR_EN, `err[1]`=1 until `zero[1]`, then 0. Without it, `err`=0 throughout.
- `zero[0]` asserted in the same cycle as a counted up step on ch0 (count 7) → `value[ch0]`=0, no step pulse. Ch1 stepping in the same cycle counts normally.
- Reset asserted mid-sequence with count 5 → all outputs 0 next cycle, priming is repeated, and the subsequent valid transitions count from 0.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: phase encodings, step kinds
// and the pure transition decoder used by every channel.
package quad_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        ILLEGAL = 2'd3
    } step_kind_t;

    // Up order is 00 -> 10 -> 11 -> 01 -> 00; both bits flipping is illegal.
    function automatic step_kind_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        step_kind_t kind;
        kind = NONE;
        if (prev == cur) begin
            kind = NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            kind = ILLEGAL;
        end else begin
            case (prev)
                S00:     kind = (cur == S10) ? UP : DOWN;
                S10:     kind = (cur == S11) ? UP : DOWN;
                S11:     kind = (cur == S01) ? UP : DOWN;
                S01:     kind = (cur == S00) ? UP : DOWN;
                default: kind = NONE;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One quadrature channel: pin synchroniser, previous-phase register, counter
// and step/dir/err outputs. Error tracking is built only when QUAD_ERR_EN is defined.
module quad_channel
    import quad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             priming,
    input  logic             a,
    input  logic             b,
    input  logic             zero,
    output logic [WIDTH-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             err
);

    localparam bit               SAT_EN     = (SATURATE != 0);
    localparam logic [WIDTH-1:0] VALUE_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] VALUE_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] VALUE_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] a_sync_r;
    logic [SYNC_STAGES-1:0] b_sync_r;
    logic [1:0]             prev_r;
    logic [WIDTH-1:0]       value_r;
    logic                   step_r;
    logic                   dir_r;

    logic [1:0]             cur_s;
    step_kind_t             kind_s;
    logic [WIDTH-1:0]       value_nxt_s;
    logic                   step_nxt_s;
    logic                   dir_nxt_s;

    assign cur_s  = {a_sync_r[SYNC_STAGES-1], b_sync_r[SYNC_STAGES-1]};
    assign kind_s = quad_decode(prev_r, cur_s);

    // Next count/step/dir: zero wins, priming counts nothing, saturation blocks the step.
    always_comb begin
        value_nxt_s = value_r;
        step_nxt_s  = 1'b0;
        dir_nxt_s   = dir_r;
        if (zero) begin
            value_nxt_s = VALUE_ZERO;
        end else if (priming) begin
            value_nxt_s = value_r;
        end else begin
            case (kind_s)
                UP: begin
                    if (SAT_EN && (value_r == VALUE_MAX)) begin
                        value_nxt_s = value_r;
                    end else begin
                        value_nxt_s = value_r + VALUE_ONE;
                        step_nxt_s  = 1'b1;
                        dir_nxt_s   = 1'b1;
                    end
                end
                DOWN: begin
                    if (SAT_EN && (value_r == VALUE_ZERO)) begin
                        value_nxt_s = value_r;
                    end else begin
                        value_nxt_s = value_r - VALUE_ONE;
                        step_nxt_s  = 1'b1;
                        dir_nxt_s   = 1'b0;
                    end
                end
                default: value_nxt_s = value_r;
            endcase
        end
    end

    // Synchroniser chain, previous phase and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync_r <= {SYNC_STAGES{1'b0}};
            b_sync_r <= {SYNC_STAGES{1'b0}};
            prev_r   <= 2'b00;
            value_r  <= VALUE_ZERO;
            step_r   <= 1'b0;
            dir_r    <= 1'b0;
        end else begin
            a_sync_r <= {a_sync_r[SYNC_STAGES-2:0], a};
            b_sync_r <= {b_sync_r[SYNC_STAGES-2:0], b};
            prev_r   <= cur_s;
            value_r  <= value_nxt_s;
            step_r   <= step_nxt_s;
            dir_r    <= dir_nxt_s;
        end
    end

    assign value = value_r;
    assign step  = step_r;
    assign dir   = dir_r;

`ifdef QUAD_ERR_EN
    logic err_r;
    logic illegal_s;

    assign illegal_s = (kind_s == ILLEGAL) && !priming;

    // Sticky error; a clear in the same cycle as a new illegal transition leaves it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (zero) begin
            err_r <= illegal_s;
        end else begin
            err_r <= err_r | illegal_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/quad_decoder.sv
// Multi-channel 4x quadrature decoder top: shared post-reset priming counter
// plus per-channel packing. Optional sticky error flags via QUAD_ERR_EN.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       b,
    input  logic [CHANNELS-1:0]       zero,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       step,
    output logic [CHANNELS-1:0]       dir,
    output logic [CHANNELS-1:0]       err
);

    localparam int SYNC_N       = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int PRIME_CYCLES = SYNC_N + 1;
    localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_CYCLES);
    localparam logic [PRIME_W-1:0] PRIME_ONE  = PRIME_W'(1);

    logic [PRIME_W-1:0] prime_cnt_r;
    logic               priming_s;

    // Priming lasts until the sync chain and prev register hold settled pin levels.
    assign priming_s = (prime_cnt_r != PRIME_LAST);

    // Prime counter restarts on every reset and parks at its terminal value.
    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt_r <= {PRIME_W{1'b0}};
        end else if (priming_s) begin
            prime_cnt_r <= prime_cnt_r + PRIME_ONE;
        end else begin
            prime_cnt_r <= prime_cnt_r;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        quad_channel #(
            .WIDTH      (WIDTH),
            .SYNC_STAGES(SYNC_N),
            .SATURATE   (SATURATE)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .priming(priming_s),
            .a      (a[i]),
            .b      (b[i]),
            .zero   (zero[i]),
            .value  (value[i*WIDTH +: WIDTH]),
            .step   (step[i]),
            .dir    (dir[i]),
            .err    (err[i])
        );
    end

endmodule
